usb3_tx_skp_insert: RTL and testbench
=====================================

Name: usb3_tx_skp_insert

Overview:
- TX link-layer stage directly upstream of the USB 3.0 32-bit data scrambler.
- Buffers link-layer words in a 4-deep FIFO and emits exactly one word per clock.
- Periodically inserts a SKP word (two SKP ordered sets) and fills gaps with logical idle.
- Drives the scrambler's data_in, scram_en and scram_rst, and provides raw data and K-flags delayed to line up with the scrambler's registered output, for the per-byte K/D mux that follows.

Parameters:
- SKP_INTERVAL, 88: number of non-SKP words emitted between consecutive SKP words (354 symbols / 4 ≈ 88). Legal range 2..1023.
- FIFO_DEPTH, 4: input FIFO depth in words. Power of two.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_data  in  32  link-layer word.
- in_datak  in  4  per-byte K flag; bit i qualifies byte i.
- in_scram_rst  in  1  qualified by in_valid; the LFSR reseeds to 16'hFFFF after this word (COM word).
- in_valid  in  1  upstream word valid.
- in_ready  out  1  FIFO can accept a word this cycle.
- skp_enable  in  1  1 = periodic SKP insertion active.
- out_data  out  32  to scrambler data_in.
- scram_en  out  1  to scrambler scram_en.
- scram_rst  out  1  to scrambler scram_rst.
- out_raw_d  out  32  out_data delayed 1 cycle; aligned with scrambler data_out.
- out_datak_d  out  4  K flags delayed 1 cycle; aligned with scrambler data_out.
- out_skp_d  out  1  high when the aligned word is a SKP word.

Behaviour:
- Reset (clock edge with reset=1):
  - All outputs are 0, including in_ready.
  - FIFO is emptied, interval counter = 0, skp_due = 0.
  - First cycle after reset: in_ready = 1.
- Handshake:
  - in_ready = (registered count < FIFO_DEPTH).
  - A push occurs on an edge where in_valid & in_ready.
  - A push and a pop in the same cycle are allowed and leave count unchanged.
  - There is no bypass path: a word pushed at edge E0 is poppable at the earliest in the cycle after E0.
- Word selection, evaluated every cycle, in priority order:
  1. skp_due = 1: SKP word. data = 32'h3C3C3C3C, k = 4'hF, scram_en = 0, scram_rst = 0. skp_due clears; counter = 0.
  2. FIFO non-empty: pop the head. Its data/k go out, scram_en = 1, scram_rst = its in_scram_rst flag.
  3. FIFO empty: logical idle. data = 0, k = 0, scram_en = 1, scram_rst = 0.
- out_data, scram_en and scram_rst are registered from the selection: visible the cycle after the selection edge.
- Latency: a word pushed into an empty FIFO at edge E0 appears on out_data after edge E1, and on out_raw_d/out_datak_d after E2.
- Interval counter (width = clog2(SKP_INTERVAL)):
  - Increments on each emitted non-SKP word (data or idle).
  - Emitting a non-SKP word with counter == SKP_INTERVAL-1 sets skp_due for the next cycle and wraps the counter to 0.
  - skp_due therefore fires exactly every SKP_INTERVAL+1 output words.
- skp_enable = 0:
  - skp_due is forced to 0 and the counter is held at 0.
  - Deasserting skp_enable while skp_due = 1 cancels the pending SKP.
  - Reasserting skp_enable restarts the count from 0.
- Scrambler coupling:
  - The scrambler's LFSR does not advance on SKP words.
  - On a scram_rst word, the scrambler scrambles that word with the current LFSR, then reseeds.
  - No special handling is required here beyond correct flag alignment.
- Delay stage: out_raw_d, out_datak_d and out_skp_d register out_data, the k flags and the SKP indication one cycle after out_data.
- Full FIFO:
  - The SKP slot still consumes an output cycle, so a sustained upstream rate of 1 word/cycle backpressures via in_ready = 0 for one cycle per interval.
  - No word is ever dropped or duplicated.
- Reset asserted mid-stream: FIFO contents are discarded. On the first edge after reset deasserts, the selection is idle.

Test Plan:
- Reset, skp_enable=1, no input, 200 cycles -> out_data 0 with scram_en=1 except one SKP every 89th word: 32'h3C3C3C3C, scram_en=0, out_datak_d=4'hF one cycle later. First SKP appears after 88 idles.
- Push 32'hDEADBEEF (k=0) into an empty FIFO at edge E0 -> out_data=DEADBEEF after E1; out_raw_d=DEADBEEF, out_datak_d=0 after E2.
- Continuous in_valid=1 for 300 cycles, incrementing data -> output sequence strictly incrementing with a SKP every 89 words. in_ready drops for ≤1 cycle per interval. No gaps in data except SKP, no loss.
- Push a word with in_scram_rst=1 and k=4'b0001 (COM in byte 0) -> scram_rst=1 in the same cycle that word is on out_data; scram_rst=0 on all neighbours; out_datak_d=4'b0001 one cycle later.
- skp_enable=0 for 500 cycles with traffic -> no SKP word ever emitted. Re-enable -> first SKP after 88 further words.
- Assert reset with 3 words in the FIFO -> all outputs 0. After release, idle is emitted (no stale words) and in_ready=1.

Source files
------------

// File: rtl/usb3_tx_skp_insert.sv
// TX link stage feeding the USB 3.0 scrambler: 4-deep word FIFO, periodic SKP
// insertion, logical idle fill, and a one-cycle delay stage for the K/D mux.
module usb3_tx_skp_insert #(
  parameter int unsigned SKP_INTERVAL = 88,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        in_scram_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        skp_enable,
  output logic [31:0] out_data,
  output logic        scram_en,
  output logic        scram_rst,
  output logic [31:0] out_raw_d,
  output logic [3:0]  out_datak_d,
  output logic        out_skp_d
);

  localparam int unsigned CW   = $clog2(SKP_INTERVAL);
  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW   = 37;
  localparam logic [31:0] SKP_WORD = 32'h3C3C3C3C;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0] count_q, count_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          skp_due_q, skp_due_d;
  logic          in_ready_q, in_ready_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    datak_q, datak_d;
  logic          scram_en_q, scram_en_d;
  logic          scram_rst_q, scram_rst_d;
  logic          skp_q, skp_d;
  logic [31:0]   raw_d_q;
  logic [3:0]    datak_d_q;
  logic          skp_d_q;

  logic          do_push, do_pop, skp_sel;
  logic [EW-1:0] head;

  // Selection, interval counter and FIFO bookkeeping
  always_comb begin
    mem_d       = mem_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    count_d     = count_q;
    cnt_d       = cnt_q;
    skp_due_d   = 1'b0;
    data_d      = 32'h0;
    datak_d     = 4'h0;
    scram_en_d  = 1'b1;
    scram_rst_d = 1'b0;
    skp_d       = 1'b0;
    head        = mem_q[rd_q];
    do_push     = in_valid & in_ready_q;
    skp_sel     = skp_due_q & skp_enable;
    do_pop      = !skp_sel && (count_q != '0);

    if (skp_sel) begin
      data_d     = SKP_WORD;
      datak_d    = 4'hF;
      scram_en_d = 1'b0;
      skp_d      = 1'b1;
      cnt_d      = '0;
    end else begin
      if (do_pop) begin
        data_d      = head[31:0];
        datak_d     = head[35:32];
        scram_rst_d = head[36];
      end
      if (cnt_q == CW'(SKP_INTERVAL - 1)) begin
        cnt_d     = '0;
        skp_due_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (!skp_enable) begin
      cnt_d     = '0;
      skp_due_d = 1'b0;
    end

    if (do_push) begin
      mem_d[wr_q] = {in_scram_rst, in_datak, in_data};
      wr_d = (wr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = (rd_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + NW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - NW'(1);
    end
    in_ready_d = (count_d < NW'(FIFO_DEPTH));
  end

  // Storage has no reset: emptiness is carried by the pointers and count
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      skp_due_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      data_q      <= 32'h0;
      datak_q     <= 4'h0;
      scram_en_q  <= 1'b0;
      scram_rst_q <= 1'b0;
      skp_q       <= 1'b0;
      raw_d_q     <= 32'h0;
      datak_d_q   <= 4'h0;
      skp_d_q     <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      skp_due_q   <= skp_due_d;
      in_ready_q  <= in_ready_d;
      data_q      <= data_d;
      datak_q     <= datak_d;
      scram_en_q  <= scram_en_d;
      scram_rst_q <= scram_rst_d;
      skp_q       <= skp_d;
      raw_d_q     <= data_q;
      datak_d_q   <= datak_q;
      skp_d_q     <= skp_q;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_data    = data_q;
  assign scram_en    = scram_en_q;
  assign scram_rst   = scram_rst_q;
  assign out_raw_d   = raw_d_q;
  assign out_datak_d = datak_d_q;
  assign out_skp_d   = skp_d_q;

endmodule

// File: tb/tb_usb3_tx_skp_insert.sv
// Randomized self-checking bench for usb3_tx_skp_insert against a word-stream model.
module tb_usb3_tx_skp_insert;

  localparam int N     = 88;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_datak;
  logic        in_scram_rst;
  logic        in_valid;
  logic        in_ready;
  logic        skp_enable;
  logic [31:0] out_data;
  logic        scram_en;
  logic        scram_rst;
  logic [31:0] out_raw_d;
  logic [3:0]  out_datak_d;
  logic        out_skp_d;

  int errors = 0;
  int checks = 0;

  usb3_tx_skp_insert #(.SKP_INTERVAL(N), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_datak(in_datak),
    .in_scram_rst(in_scram_rst), .in_valid(in_valid), .in_ready(in_ready),
    .skp_enable(skp_enable), .out_data(out_data), .scram_en(scram_en),
    .scram_rst(scram_rst), .out_raw_d(out_raw_d), .out_datak_d(out_datak_d),
    .out_skp_d(out_skp_d)
  );

  always #5 clock = ~clock;

  // Word-stream model: queue of accepted words, words since last SKP, pending SKP
  logic [36:0] mq[$];
  int          since;
  bit          pending;
  bit          m_ready, m_pushed;
  logic [31:0] e_data, e_raw_d;
  logic [3:0]  e_k, e_k_d;
  logic        e_en, e_rst, e_skp, e_skp_d;
  logic [36:0] w;

  task automatic model_edge();
    m_pushed = 1'b0;
    if (reset) begin
      mq.delete();
      since = 0; pending = 0; m_ready = 0;
      e_data = '0; e_k = '0; e_en = 0; e_rst = 0; e_skp = 0;
      e_raw_d = '0; e_k_d = '0; e_skp_d = 0;
      return;
    end
    e_raw_d = e_data; e_k_d = e_k; e_skp_d = e_skp;
    m_pushed = in_valid && m_ready;
    if (skp_enable && pending) begin
      e_data = 32'h3C3C3C3C; e_k = 4'hF; e_en = 0; e_rst = 0; e_skp = 1;
      pending = 0; since = 0;
    end else begin
      if (mq.size() > 0) begin
        w = mq.pop_front();
        e_data = w[31:0]; e_k = w[35:32]; e_rst = w[36];
      end else begin
        e_data = '0; e_k = '0; e_rst = 0;
      end
      e_en = 1; e_skp = 0;
      since++;
      if (since == N) begin pending = 1; since = 0; end
    end
    if (!skp_enable) begin since = 0; pending = 0; end
    if (m_pushed) mq.push_back({in_scram_rst, in_datak, in_data});
    m_ready = (mq.size() < DEPTH);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  function automatic logic [71:0] act_vec();
    return {out_data, scram_en, scram_rst, out_raw_d, out_datak_d, out_skp_d, in_ready};
  endfunction

  function automatic logic [71:0] exp_vec();
    return {e_data, e_en, e_rst, e_raw_d, e_k_d, e_skp_d, m_ready};
  endfunction

  task automatic test_reset();
    reset = 1; in_valid = 0; skp_enable = 1;
    in_data = '0; in_datak = '0; in_scram_rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act_vec() !== 72'h0) begin
        errors++; $display("FAIL reset_outputs: got %h expected 0", act_vec());
      end
    end
    reset = 0;
    tick();
    checks++;
    if ({in_ready, scram_en, out_data} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL reset_release: ready=%b en=%b data=%h expected 1 1 0",
                         in_ready, scram_en, out_data);
    end
  endtask

  task automatic test_idle_skp();
    int first_skp, skp_cnt, kd_ok;
    reset = 1; tick(); tick(); reset = 0;
    first_skp = -1; skp_cnt = 0; kd_ok = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL idle_stream c=%0d: got %h expected %h", c, act_vec(), exp_vec());
      end
      if (out_data === 32'h3C3C3C3C && scram_en === 1'b0) begin
        skp_cnt++;
        if (first_skp < 0) first_skp = c;
      end
      if (c == 90 && out_datak_d === 4'hF && out_skp_d === 1'b1) kd_ok = 1;
    end
    checks++;
    if (first_skp != 89) begin
      errors++; $display("FAIL idle_first_skp: got %0d expected 89", first_skp);
    end
    checks++;
    if (skp_cnt != 2) begin
      errors++; $display("FAIL idle_skp_count: got %0d expected 2", skp_cnt);
    end
    checks++;
    if (kd_ok != 1) begin
      errors++; $display("FAIL idle_skp_datak_d: got %0d expected 1", kd_ok);
    end
  endtask

  task automatic test_latency();
    reset = 1; tick(); reset = 0; tick();
    in_valid = 1; in_data = 32'hDEADBEEF; in_datak = 4'h0; in_scram_rst = 0;
    tick();
    in_valid = 0;
    tick();
    checks++;
    if ({out_data, scram_en} !== {32'hDEADBEEF, 1'b1}) begin
      errors++; $display("FAIL latency_e1: got %h/%b expected deadbeef/1", out_data, scram_en);
    end
    tick();
    checks++;
    if ({out_raw_d, out_datak_d} !== {32'hDEADBEEF, 4'h0}) begin
      errors++; $display("FAIL latency_e2: got %h/%h expected deadbeef/0", out_raw_d, out_datak_d);
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL latency_model: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_stream();
    logic [31:0] last;
    int low_run, bad_order, bad_ready, skps;
    bit seen;
    in_valid = 1; in_data = 32'h0000_1000; in_datak = 0; in_scram_rst = 0;
    seen = 0; low_run = 0; bad_order = 0; bad_ready = 0; skps = 0; last = '0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (m_pushed) in_data = in_data + 32'd1;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL stream c=%0d: got %h expected %h", c, act_vec(), exp_vec());
      end
      if (scram_en && out_data != 32'h0) begin
        if (seen && out_data != last + 32'd1) bad_order++;
        seen = 1; last = out_data;
      end
      if (!scram_en) skps++;
      low_run = in_ready ? 0 : low_run + 1;
      if (low_run > 1) bad_ready++;
    end
    in_valid = 0;
    checks++;
    if (bad_order != 0) begin
      errors++; $display("FAIL stream_order: got %0d breaks expected 0", bad_order);
    end
    checks++;
    if (bad_ready != 0) begin
      errors++; $display("FAIL stream_ready_low: got %0d long stalls expected 0", bad_ready);
    end
    checks++;
    if (skps < 3 || skps > 4) begin
      errors++; $display("FAIL stream_skp_count: got %0d expected 3..4", skps);
    end
  endtask

  task automatic test_scram_rst();
    int rst_seen, align_ok, k_ok;
    in_valid = 0;
    for (int i = 0; i < 8; i++) tick();
    in_valid = 1; in_data = 32'h0000_00BC; in_datak = 4'b0001; in_scram_rst = 1;
    tick();
    in_valid = 0; in_scram_rst = 0; in_datak = 0;
    rst_seen = 0; align_ok = 0; k_ok = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL scram_rst_model i=%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      if (k_ok == -1) k_ok = (out_datak_d === 4'b0001) ? 1 : 0;
      if (scram_rst === 1'b1) begin
        rst_seen++;
        if (out_data === 32'h0000_00BC) align_ok = 1;
        k_ok = -1;
      end
    end
    checks++;
    if (rst_seen != 1 || align_ok != 1 || k_ok != 1) begin
      errors++; $display("FAIL scram_rst_align: got seen=%0d align=%0d k=%0d expected 1 1 1",
                         rst_seen, align_ok, k_ok);
    end
  endtask

  task automatic test_disable();
    int skp_seen, first_skp;
    skp_enable = 0; skp_seen = 0;
    for (int c = 0; c < 500; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom; in_datak = 4'($urandom); in_scram_rst = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL disable c=%0d: got %h expected %h", c, act_vec(), exp_vec());
      end
      if (!scram_en || out_skp_d) skp_seen++;
    end
    checks++;
    if (skp_seen != 0) begin
      errors++; $display("FAIL disable_no_skp: got %0d expected 0", skp_seen);
    end
    skp_enable = 1; first_skp = -1;
    for (int c = 1; c <= 100; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom; in_datak = 4'($urandom); in_scram_rst = 0;
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL reenable c=%0d: got %h expected %h", c, act_vec(), exp_vec());
      end
      if (!scram_en && first_skp < 0) first_skp = c;
    end
    in_valid = 0;
    checks++;
    if (first_skp != 89) begin
      errors++; $display("FAIL reenable_first_skp: got %0d expected 89", first_skp);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1; in_data = 32'h0000_5000; in_datak = 0; in_scram_rst = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_pushed) in_data = in_data + 32'd1;
    end
    reset = 1;
    tick(); tick();
    checks++;
    if (act_vec() !== 72'h0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h expected 0", act_vec());
    end
    reset = 0; in_valid = 0;
    tick();
    checks++;
    if ({out_data, scram_en, scram_rst, in_ready} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_mid_idle: got %h/%b/%b/%b expected 0/1/0/1",
                         out_data, scram_en, scram_rst, in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec() || out_data !== 32'h0) begin
        errors++; $display("FAIL reset_mid_stale c=%0d: got %h expected %h", c, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_skp();
    test_latency();
    test_stream();
    test_scram_rst();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
